// File: rtl/sec_an_pkg.sv
// Shared constants, status codes and controller states for the A=17619 AN-code
// single-error-correction search controller.
package sec_an_pkg;

    localparam int N  = 43;
    localparam int RW = 15;
    localparam int LW = 7;
    localparam int A  = 17619;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_FIX  = 2'd1,
        ERR_UNC  = 2'd2
    } err_t;

    typedef enum logic [2:0] {
        IDLE,
        RESID,
        SEARCH,
        FIX,
        DONE
    } state_t;

    // Search order: even index i -> +(i/2+1), odd index i -> -(i/2+1).
    function automatic logic signed [LW-1:0] cand_loc(input logic [LW-1:0] i);
        logic [LW-1:0] m;
        m = (i >> 1) + LW'(1);
        return i[0] ? $signed(-m) : $signed(m);
    endfunction

endpackage

// File: rtl/sec_an_search_ctrl_if.sv
// Codeword-in / result-out handshake plus the shared LUT port of the controller.
interface sec_an_search_ctrl_if;
    import sec_an_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [N-1:0]         in_cw;
    logic                 out_valid;
    logic                 out_ready;
    logic [N-1:0]         out_cw;
    logic [1:0]           out_err;
    logic signed [LW-1:0] out_loc;
    logic signed [LW-1:0] lut_l;
    logic [RW-1:0]        lut_r;

    modport master (
        output in_valid, in_cw, out_ready, lut_r,
        input  in_ready, out_valid, out_cw, out_err, out_loc, lut_l
    );

    modport slave (
        input  in_valid, in_cw, out_ready, lut_r,
        output in_ready, out_valid, out_cw, out_err, out_loc, lut_l
    );

endinterface

// File: rtl/sec_an_residue_serial.sv
// Bit-serial mod-A accumulator, MSB first: s <- (2*s + bit) mod A.
module sec_an_residue_serial
    import sec_an_pkg::*;
(
    input  logic          clk,
    input  logic          clear,
    input  logic          step,
    input  logic          bit_in,
    output logic [RW-1:0] s
);

    localparam logic [RW:0] A_W = (RW+1)'(A);

    logic [RW:0] t;

    // s < A keeps t < 2A, so a single conditional subtract suffices.
    assign t = {s, bit_in};

    always_ff @(posedge clk) begin
        if (clear) begin
            s <= '0;
        end else if (step) begin
            s <= (t >= A_W) ? RW'(t - A_W) : t[RW-1:0];
        end
    end

endmodule

// File: rtl/sec_an_search_ctrl.sv
// Sequential AN-code corrector: serial residue, then a signed-location sweep of
// the external remainder LUT, then a single +/-2^k fix-up of the codeword.
module sec_an_search_ctrl
    import sec_an_pkg::*;
(
    input logic                 clk,
    input logic                 rst_n,
    sec_an_search_ctrl_if.slave bus
);

    state_t               state;
    logic                 accept;
    logic                 valid_q;
    logic [N-1:0]         cw_q;
    logic [N-1:0]         res_cw;
    err_t                 res_err;
    logic signed [LW-1:0] res_loc;
    logic signed [LW-1:0] lut_loc;
    logic signed [LW-1:0] loc_q;
    logic [5:0]           bit_idx;
    logic                 res_last;
    logic [LW-1:0]        idx;

    logic [RW-1:0]        s;
    logic                 res_clear;
    logic                 res_step;

    logic [LW-1:0]        loc_mag;
    logic [N:0]           delta;
    logic [N:0]           fix_sum;

    assign res_clear = (state == IDLE) && bus.in_valid;
    assign res_step  = (state == RESID) && !res_last;

    sec_an_residue_serial u_resid (
        .clk    (clk),
        .clear  (res_clear),
        .step   (res_step),
        .bit_in (cw_q[bit_idx]),
        .s      (s)
    );

    // Bit N of the N+1-bit result flags a borrow below zero or a carry past 2^N.
    assign loc_mag = loc_q[LW-1] ? LW'(-loc_q) : LW'(loc_q);
    assign delta   = (N+1)'(1) << (loc_mag - LW'(1));
    assign fix_sum = loc_q[LW-1] ? ({1'b0, cw_q} + delta) : ({1'b0, cw_q} - delta);

    assign bus.in_ready  = accept;
    assign bus.out_valid = valid_q;
    assign bus.out_cw    = res_cw;
    assign bus.out_err   = res_err;
    assign bus.out_loc   = res_loc;
    assign bus.lut_l     = lut_loc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            accept   <= 1'b1;
            valid_q  <= 1'b0;
            res_cw   <= '0;
            res_err  <= ERR_NONE;
            res_loc  <= '0;
            lut_loc  <= '0;
            bit_idx  <= '0;
            res_last <= 1'b0;
            idx      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        cw_q     <= bus.in_cw;
                        bit_idx  <= 6'(N - 1);
                        res_last <= 1'b0;
                        accept   <= 1'b0;
                        state    <= RESID;
                    end
                end
                // N accumulate cycles, then one cycle to inspect the final residue.
                RESID: begin
                    if (!res_last) begin
                        if (bit_idx == 6'd0) begin
                            res_last <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx - 6'd1;
                        end
                    end else if (s == '0) begin
                        res_cw  <= cw_q;
                        res_err <= ERR_NONE;
                        res_loc <= '0;
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end else begin
                        idx     <= '0;
                        lut_loc <= cand_loc('0);
                        state   <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (bus.lut_r == s) begin
                        loc_q   <= lut_loc;
                        lut_loc <= '0;
                        state   <= FIX;
                    end else if (idx == LW'(2 * N - 1)) begin
                        lut_loc <= '0;
                        res_cw  <= cw_q;
                        res_err <= ERR_UNC;
                        res_loc <= '0;
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end else begin
                        idx     <= idx + LW'(1);
                        lut_loc <= cand_loc(idx + LW'(1));
                    end
                end
                FIX: begin
                    if (fix_sum[N]) begin
                        res_cw  <= cw_q;
                        res_err <= ERR_UNC;
                        res_loc <= '0;
                    end else begin
                        res_cw  <= fix_sum[N-1:0];
                        res_err <= ERR_FIX;
                        res_loc <= loc_q;
                    end
                    valid_q <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        accept  <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sec_an_search_ctrl.sv
// Scoreboard bench for sec_an_search_ctrl: a residue/search reference model feeds
// an expectation queue that a free-running output monitor drains.
module tb_sec_an_search_ctrl;
    import sec_an_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sec_an_search_ctrl_if bus();

    sec_an_search_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        longint cw;
        longint err;
        longint loc;
        longint lat;
        int     n_sweep;
    } exp_t;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    exp_t   q[$];
    int     loc_order[$];
    logic signed [LW-1:0] sweep[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Remainder of the error value a single-bit error at location l adds to a codeword.
    function automatic longint lut_ref(input int l);
        longint p;
        if (l == 0) return 0;
        p = longint'(1) << ((l > 0 ? l : -l) - 1);
        if (l > 0) return p % A;
        return (A - (p % A)) % A;
    endfunction

    always_comb bus.lut_r = RW'(lut_ref(int'(bus.lut_l)));

    function automatic exp_t model(input longint cw);
        exp_t   e;
        longint res;
        longint mag;
        int     l;
        res = cw % A;
        e.cw = cw; e.err = 0; e.loc = 0; e.lat = 44; e.n_sweep = 0;
        if (res == 0) return e;
        for (int j = 0; j < loc_order.size(); j++) begin
            l = loc_order[j];
            if (lut_ref(l) == res) begin
                mag = longint'(1) << ((l > 0 ? l : -l) - 1);
                e.lat = 46 + j;
                e.n_sweep = j + 1;
                if (l > 0 && mag <= cw) begin
                    e.cw = cw - mag; e.err = 1; e.loc = l;
                end else if (l < 0 && cw + mag < (longint'(1) << N)) begin
                    e.cw = cw + mag; e.err = 1; e.loc = l;
                end else begin
                    e.err = 2;
                end
                return e;
            end
        end
        e.err = 2;
        e.lat = 44 + 2 * N;
        e.n_sweep = 2 * N;
        return e;
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_in_ready"},  longint'(bus.in_ready), 1);
        chk({tag, "_out_valid"}, longint'(bus.out_valid), 0);
        chk({tag, "_out_cw"},    longint'(bus.out_cw), 0);
        chk({tag, "_out_err"},   longint'(bus.out_err), 0);
        chk({tag, "_out_loc"},   longint'(bus.out_loc), 0);
        chk({tag, "_lut_l"},     longint'(bus.lut_l), 0);
    endtask

    // Output monitor: hold stability under backpressure, then scoreboard compare.
    initial begin
        logic                 seen;
        logic                 ready_next;
        logic [N-1:0]         h_cw;
        logic [1:0]           h_err;
        logic signed [LW-1:0] h_loc;
        longint               first_cyc;
        exp_t                 e;
        logic                 sweep_ok;
        seen = 1'b0;
        ready_next = 1'b0;
        first_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0;
                ready_next = 1'b0;
                sweep.delete();
            end else begin
                if (ready_next) begin
                    chk("in_ready_rise", longint'(bus.in_ready), 1);
                    ready_next = 1'b0;
                end
                if (bus.lut_l != '0) sweep.push_back(bus.lut_l);
                if (bus.out_valid) begin
                    if (!seen) begin
                        seen = 1'b1;
                        first_cyc = cyc;
                        h_cw = bus.out_cw; h_err = bus.out_err; h_loc = bus.out_loc;
                    end else begin
                        chk("hold_cw",  longint'(bus.out_cw),  longint'(h_cw));
                        chk("hold_err", longint'(bus.out_err), longint'(h_err));
                        chk("hold_loc", longint'(bus.out_loc), longint'(h_loc));
                    end
                    if (!bus.out_ready) chk("in_ready_busy", longint'(bus.in_ready), 0);
                    if (bus.out_ready) begin
                        if (q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL spurious_out actual=out_valid required=no_output cw=%0d", bus.out_cw);
                        end else begin
                            e = q.pop_front();
                            chk("out_cw",  longint'(bus.out_cw), e.cw);
                            chk("out_err", longint'(bus.out_err), e.err);
                            chk("out_loc", longint'(bus.out_loc), e.loc);
                            chk("latency", first_cyc, e.lat);
                            sweep_ok = (sweep.size() == e.n_sweep);
                            for (int k = 0; k < sweep.size() && sweep_ok; k++)
                                if (int'(sweep[k]) != loc_order[k]) sweep_ok = 1'b0;
                            chk("lut_sweep_len", longint'(sweep.size()), longint'(e.n_sweep));
                            chk("lut_sweep_order", longint'(sweep_ok), 1);
                        end
                        seen = 1'b0;
                        ready_next = 1'b1;
                        sweep.delete();
                    end
                end
            end
        end
    end

    task automatic send(input longint cw);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout in_ready=%0b required=1", bus.in_ready);
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_cw = N'(cw);
        @(posedge clk);
        #1;
        e = model(cw);
        e.lat += cyc;
        q.push_back(e);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || !bus.in_ready) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0 || !bus.in_ready) begin
            checks++; errors++;
            $display("FAIL drain_timeout pending=%0d required=0", q.size());
        end
    endtask

    function automatic longint rand_cw();
        longint k;
        longint cw;
        int     e;
        k = longint'({$urandom, $urandom} % 64'd499239000);
        cw = k * A;
        e = $urandom_range(0, N - 1);
        case ($urandom_range(0, 3))
            0: ;
            1: cw = cw + (longint'(1) << e);
            2: cw = cw - (longint'(1) << e);
            default: cw = longint'({$urandom, $urandom});
        endcase
        return cw & ((longint'(1) << N) - 1);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int n;
        for (int k = 1; k <= N; k++) begin
            loc_order.push_back(k);
            loc_order.push_back(-k);
        end
        bus.in_valid = 1'b0;
        bus.in_cw = '0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset("reset");

        send(17619000);
        send(17620);
        send(55327);
        send(17622);
        send(15149);
        send((longint'(1) << N) - 1);
        drain();

        // Backpressure, with a junk offer that must be ignored while busy.
        @(posedge clk); #1 bus.out_ready = 1'b0;
        send(17619 * 123 + (1 << 9));
        n = 0;
        while (!bus.out_valid && n < 300) begin
            @(posedge clk); #1; n++;
        end
        chk("bp_out_valid", longint'(bus.out_valid), 1);
        bus.in_valid = 1'b1;
        bus.in_cw = N'(12345);
        repeat (10) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        send(17619 * 7 + (1 << 20));
        drain();

        // Reset while the search sits at index 10 (lut_l = +6).
        send(17622);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (bus.lut_l != 7'sd6 && n < 300);
        chk("rst_search_reach", longint'(bus.lut_l), 6);
        rst_n = 1'b0;
        q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset("midrst");
        repeat (150) @(posedge clk);
        send(55327);
        drain();

        for (int t = 0; t < 40; t++) send(rand_cw());
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
